// File: rtl/rf_wr_arbiter.sv
// Two-requester arbiter for the register file write port: B has priority, A
// takes the port once it has been refused MAX_WAIT cycles in a row.
module rf_wr_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_addr,
  input  logic [31:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_addr,
  input  logic [31:0]      b_data,
  output logic             rf_we,
  output logic [4:0]       rf_addr,
  output logic [31:0]      rf_data,
  output logic             a_starved,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic             a_need, b_need, both_need;
  logic             grant_a, grant_b;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  assign a_need    = a_valid && (a_addr != 5'd0);
  assign b_need    = b_valid && (b_addr != 5'd0);
  assign both_need = a_need && b_need;
  assign a_starved = (wait_cnt_q == MAX_WAIT_C);

  assign grant_a = a_need && (!b_need || a_starved);
  assign grant_b = b_need && !grant_a;

  // Address-0 writes are absorbed here; the register file never sees them.
  assign a_ready = rst && (grant_a || (a_valid && (a_addr == 5'd0)));
  assign b_ready = rst && (grant_b || (b_valid && (b_addr == 5'd0)));

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rf_we_d        = grant_a || grant_b;
    rf_addr_d      = rf_addr_q;
    rf_data_d      = rf_data_q;
    wait_cnt_d     = 4'd0;
    conflict_cnt_d = conflict_cnt_q;

    if (grant_a) begin
      rf_addr_d = a_addr;
      rf_data_d = a_data;
    end else if (grant_b) begin
      rf_addr_d = b_addr;
      rf_data_d = b_data;
    end

    if (a_need && !grant_a && (wait_cnt_q != MAX_WAIT_C))
      wait_cnt_d = wait_cnt_q + 4'd1;
    else if (a_need && !grant_a)
      wait_cnt_d = wait_cnt_q;

    if (both_need && (conflict_cnt_q != {CNT_W{1'b1}}))
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q        <= 1'b0;
      rf_addr_q      <= 5'd0;
      rf_data_q      <= 32'd0;
      wait_cnt_q     <= 4'd0;
      conflict_cnt_q <= '0;
    end else begin
      rf_we_q        <= rf_we_d;
      rf_addr_q      <= rf_addr_d;
      rf_data_q      <= rf_data_d;
      wait_cnt_q     <= wait_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_addr      = rf_addr_q;
  assign rf_data      = rf_data_q;
  assign conflict_cnt = conflict_cnt_q;

  // Requesters must hold a refused request unchanged until it is accepted.
  a_stable_chk: assert property (@(posedge clk) disable iff (!rst)
    (a_valid && !a_ready) |=> (a_valid && $stable(a_addr) && $stable(a_data)));
  b_stable_chk: assert property (@(posedge clk) disable iff (!rst)
    (b_valid && !b_ready) |=> (b_valid && $stable(b_addr) && $stable(b_data)));

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: reset, single requester, priority and
// starvation override, address-0 bypass, same-address ordering, saturation.
module tb_rf_wr_arbiter;

  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, b_valid;
  logic             a_ready, b_ready;
  logic [4:0]       a_addr, b_addr;
  logic [31:0]      a_data, b_data;
  logic             rf_we;
  logic [4:0]       rf_addr;
  logic [31:0]      rf_data;
  logic             a_starved;
  logic [CNT_W-1:0] conflict_cnt;

  int checks = 0;
  int errors = 0;
  int exp_conflict = 0;
  logic [31:0] rf_model [32];

  rf_wr_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .a_starved(a_starved), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register file behind the write port.
  always @(posedge clk) if (rf_we) rf_model[rf_addr] <= rf_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h5555_0005;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h6666_0006;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_b_ready", 32'(b_ready), 32'd1);
    chk("rel_a_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    exp_conflict = 1;
    chk("rel_rf_we", 32'(rf_we), 32'd1);
    chk("rel_rf_addr", 32'(rf_addr), 32'd6);
    chk("rel_conflict", 32'(conflict_cnt), 32'(exp_conflict));
    b_valid = 1'b0;
    #1;
    chk("rel_a_ready_next", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("rel_a_write", 32'(rf_addr), 32'd5);
  endtask

  task automatic test_single();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hDEAD_BEEF;
    #1;
    chk("single_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("single_rf_we", 32'(rf_we), 32'd1);
    chk("single_rf_addr", 32'(rf_addr), 32'd7);
    chk("single_rf_data", rf_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("single_rf_we_off", 32'(rf_we), 32'd0);
    chk("single_rf_addr_hold", 32'(rf_addr), 32'd7);
  endtask

  task automatic test_starvation();
    logic [4:0] b_seq [4];
    b_seq = '{5'd2, 5'd3, 5'd4, 5'd5};
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_0011;
    b_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      b_addr = b_seq[c]; b_data = 32'h100 + 32'(b_seq[c]);
      #1;
      chk("starve_b_ready", 32'(b_ready), 32'd1);
      chk("starve_a_refused", 32'(a_ready), 32'd0);
      chk("starve_flag_low", 32'(a_starved), 32'd0);
      @(negedge clk);
      chk("starve_b_write", 32'(rf_addr), 32'(b_seq[c]));
    end
    b_addr = 5'd5; b_data = 32'h105;
    #1;
    chk("override_a_ready", 32'(a_ready), 32'd1);
    chk("override_b_refused", 32'(b_ready), 32'd0);
    chk("override_flag", 32'(a_starved), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("override_a_write", 32'(rf_addr), 32'd1);
    chk("override_a_data", rf_data, 32'h0000_0011);
    #1;
    chk("after_b_ready", 32'(b_ready), 32'd1);
    chk("after_flag_low", 32'(a_starved), 32'd0);
    @(negedge clk);
    b_valid = 1'b0;
    exp_conflict += 4;
    chk("after_b_write", 32'(rf_addr), 32'd5);
    chk("starve_conflict", 32'(conflict_cnt), 32'(exp_conflict));
  endtask

  task automatic test_zero_addr();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hBAD0_0000;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_0009;
    #1;
    chk("zero_a_ready", 32'(a_ready), 32'd1);
    chk("zero_b_ready", 32'(b_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    chk("zero_rf_addr", 32'(rf_addr), 32'd9);
    chk("zero_rf_data", rf_data, 32'h0000_0009);
    chk("zero_conflict", 32'(conflict_cnt), 32'(exp_conflict));
    chk("zero_no_wait", 32'(a_starved), 32'd0);
    @(negedge clk);
    chk("zero_rf_we_off", 32'(rf_we), 32'd0);
  endtask

  task automatic test_same_addr();
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd12; b_data = 32'h2;
    #1;
    chk("same_b_first", 32'(b_ready), 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    exp_conflict += 1;
    chk("same_b_data", rf_data, 32'h2);
    #1;
    chk("same_a_second", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("same_a_data", rf_data, 32'h1);
    chk("same_conflict", 32'(conflict_cnt), 32'(exp_conflict));
    repeat (2) @(negedge clk);
    chk("same_final_reg12", rf_model[12], 32'h1);
  endtask

  task automatic test_saturation();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    repeat (70000) @(negedge clk);
    chk("sat_value", 32'(conflict_cnt), 32'h0000_FFFF);
    repeat (10) @(negedge clk);
    chk("sat_hold", 32'(conflict_cnt), 32'h0000_FFFF);
    // Reset in the middle of traffic cancels the write in flight.
    rst = 1'b0;
    #1;
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    chk("midrst_conflict", 32'(conflict_cnt), 32'd0);
    chk("midrst_a_ready", 32'(a_ready), 32'd0);
    chk("midrst_b_ready", 32'(b_ready), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_idle_we", 32'(rf_we), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    test_reset();
    test_single();
    test_starvation();
    test_zero_addr();
    test_same_addr();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU/execute result) and B (memory load return).
- Uses valid/ready handshakes and fixed priority to B, with an anti-starvation override for A.
- Drives registered write-enable, address and data straight into the register file write port.
- Exposes a saturating conflict counter for performance debug.

Parameters:
- MAX_WAIT, 3, consecutive cycles A may be refused while valid before it overrides B; legal range 1..15.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- a_valid  in  1  requester A holds a write.
- a_ready  out  1  A's write is accepted this cycle (combinational).
- a_addr  in  5  A destination register.
- a_data  in  32  A write data.
- b_valid  in  1  requester B holds a write.
- b_ready  out  1  B's write is accepted this cycle (combinational).
- b_addr  in  5  B destination register.
- b_data  in  32  B write data.
- rf_we  out  1  register file write enable (registered).
- rf_addr  out  5  register file write address (registered).
- rf_data  out  32  register file write data (registered).
- a_starved  out  1  A override currently active (registered state, visible combinationally).
- conflict_cnt  out  CNT_W  count of cycles in which A and B both needed the port; saturates.

Behaviour:
- Reset (rst low, asynchronous):
  - rf_we=0, rf_addr=0, rf_data=0, wait_cnt=0, a_starved=0, conflict_cnt=0.
  - a_ready and b_ready are 0 while rst is low.
- Needs port: X needs the port when x_valid=1 and x_addr!=0.
- Zero-address writes: a valid request with addr 0 is accepted in the same cycle (x_ready=1), never reaches the port, and does not affect wait_cnt.
- Arbitration, combinational within the cycle:
  - Only A needs port: grant A.
  - Only B needs port: grant B.
  - Both need port and wait_cnt<MAX_WAIT: grant B.
  - Both need port and wait_cnt==MAX_WAIT: grant A; a_starved=1 this cycle.
  - x_ready=1 when X is granted or X has a valid addr-0 request; otherwise 0.
- Output register, on each rising edge:
  - rf_we <= (grant exists).
  - rf_addr/rf_data <= granted requester's addr/data.
  - With no grant, rf_we <= 0 and rf_addr/rf_data hold their previous values.
  - Latency: handshake at cycle N produces the register file write at edge N+1, so the data is visible in the register file after edge N+2.
- wait_cnt (4 bits):
  - Increments when A needs the port and is not granted.
  - Clears to 0 when A is granted or A does not need the port.
  - Never exceeds MAX_WAIT.
- a_starved is combinational from (wait_cnt==MAX_WAIT).
- conflict_cnt increments on every cycle where both need the port, and holds at all-ones.
- Requester rule (checked by assertion): once x_valid is asserted, x_valid/x_addr/x_data stay stable until x_ready.
- Same nonzero address from both in one cycle: no merging; each is written in grant order, so the last granted requester's data wins.
- Reset mid-operation: pending unaccepted requests are dropped by the arbiter. Requesters must re-present them after rst rises. Any write in flight in the output register is cancelled (rf_we forced 0).

Test Plan:
- Reset: hold rst low with both valid (addr 5, 6) -> a_ready=b_ready=0, rf_we=0, conflict_cnt=0; release rst -> B granted first cycle.
- Single requester: A valid, addr 7, data 0xDEADBEEF, one cycle -> a_ready=1 that cycle; next edge rf_we=1, rf_addr=7, rf_data=0xDEADBEEF; following edge rf_we=0.
- Priority and starvation, MAX_WAIT=3: A (addr 1) and B (addrs 2,3,4,5) continuously valid -> B granted cycles 0-2; A granted cycle 3 with a_starved=1; B (addr 5) granted cycle 4; conflict_cnt=4.
- Zero address: A addr 0 and B addr 9 valid together -> a_ready=1 and b_ready=1 same cycle; only rf_addr=9 written; conflict_cnt unchanged; wait_cnt=0.
- Same address: A and B both addr 12, A data 0x1, B data 0x2 -> writes occur B then A on consecutive edges; final register 12 = 0x1.
- Saturation: force 70000 conflict cycles with CNT_W=16 -> conflict_cnt=0xFFFF and holds.
